fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Read-side companion to fifo_basic. It drives the FIFO's rd_en/empty/data_out port, absorbs its one-cycle registered read latency, and presents words as a valid/ready stream to downstream consumers such as the DDR model command path. A 2-entry local buffer sustains one word per cycle under backpressure. A flush input drains the FIFO, and a handshake counter supports debug.

Parameters:
DATA_WIDTH, 32, word width; must match the fifo_basic instance.
CNT_WIDTH, 16, width of pop_count.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
fifo_empty  in  1  empty flag from fifo_basic
fifo_rd_en  out  1  read strobe to fifo_basic
fifo_data  in  DATA_WIDTH  fifo_basic data_out, valid the cycle after an accepted rd_en
m_valid  out  1  stream word valid
m_ready  in  1  consumer accepts word
m_data  out  DATA_WIDTH  stream word (buffer head)
flush  in  1  drain and discard mode
occupancy  out  2  local buffer entries (0..2)
pop_count  out  CNT_WIDTH  count of completed m_valid&&m_ready handshakes

Behaviour:
- One clock domain. Reset is synchronous and active-high, named clk/reset. While reset is high:
  - fifo_rd_en=0, m_valid=0, m_data=0, occupancy=0, pop_count=0
  - in-flight flag cleared
  - both buffer entries invalidated
- inflight register: 1 in the cycle after fifo_rd_en=1, else 0.
- pop = m_valid && m_ready && !flush.
- fifo_rd_en is combinational: !reset && !fifo_empty && (flush || (occupancy + inflight - pop) < 2).
  - Never asserted while fifo_empty=1.
- Data capture: when inflight=1 and flush=0, fifo_data is written into the buffer tail at the clock edge. Ordering is strictly FIFO.
- Buffer: 2 entries, head drives m_data, m_valid = (occupancy != 0).
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0.
  - Simultaneous capture and pop: head advances and the new word enters, so occupancy is unchanged.
  - Occupancy can never exceed 2, by construction of the rd_en rule. An internal assertion flags overflow.
- Latency: rd_en in cycle t, fifo_data valid in t+1, m_valid=1 in t+2. Steady-state throughput is 1 word/cycle with m_ready held high.
- Backpressure: with m_ready=0, at most 2 words are removed from the FIFO; rd_en then stays 0.
- flush=1:
  - m_valid forced to 0 combinationally; the buffer is invalidated at the next edge.
  - Words arriving from in-flight reads are discarded.
  - rd_en is asserted every cycle the FIFO is non-empty.
  - pop_count does not increment.
- After flush deasserts, normal operation resumes from an empty local buffer. The first word becomes visible 2 cycles after the first rd_en.
- pop_count increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-operation clears everything. A word arriving the cycle after reset deasserts, from a pre-reset rd_en, is dropped because inflight was cleared.

Decomposition:
- Package fifo_stream_pkg:
  - localparam BUF_DEPTH=2
  - typedef occ_t (logic [1:0])
  - localparam occupancy constants OCC_EMPTY/OCC_ONE/OCC_FULL
- One sub-module: stream_buf2, a 2-entry ordered buffer with push/pop/flush/occupancy. The top keeps rd_en credit logic, inflight, and pop_count.

Test Plan:
- Reset, then write 4 words (0x11111111, 0x22222222, 0x33333333, 0x44444444) into fifo_basic with m_ready=1 → m_valid in 4 consecutive cycles, data in order, first m_valid 2 cycles after first rd_en, pop_count=4.
- 4 words buffered, m_ready=0 for 10 cycles → exactly 2 rd_en pulses, occupancy=2, m_data=0x11111111 stable; then m_ready=1 → remaining 3 words delivered back-to-back, no loss or duplication.
- Toggle m_ready 1,0,1,0 on an 8-word burst (0x0..0x7) → all 8 delivered in order, rd_en never high while fifo_empty=1, occupancy ≤2 throughout.
- 6 words in FIFO, 2 in local buffer, assert flush for 8 cycles → m_valid=0, FIFO reaches empty, pop_count unchanged. Then write 0xA5A5A5A5 → it is the next word delivered.
- Assert reset for 1 cycle while a read is in flight and occupancy=2 → all outputs return to reset values, the stale word is not delivered, and a subsequent write of 0xDEADBEEF is delivered correctly.
- Preload pop_count near wrap (CNT_WIDTH=4, 17 handshakes) → pop_count=1 after the 17th handshake.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the fifo_basic read-side stream adapter.
// Holds the local buffer geometry and the read-credit rule.
package fifo_stream_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Words already held or on their way, less the one leaving this cycle,
  // must leave room for one more so an issued read always has a slot.
  function automatic logic has_credit(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return committed < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry ordered buffer; entry 0 is always the head.
// Supports simultaneous push and pop, and a flush that empties it.
module stream_buf2
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head_data,
  output occ_t                  occupancy
);

  logic [DATA_WIDTH-1:0] entry_reg [BUF_DEPTH];
  occ_t                  occ_reg;
  logic                  pop_ok;
  logic                  push_ok;

  // A pop of an empty buffer or a push into a full one without a pop is ignored.
  assign pop_ok  = pop && (occ_reg != OCC_EMPTY);
  assign push_ok = push && ((occ_reg != OCC_FULL) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_reg      <= OCC_EMPTY;
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (occ_reg == OCC_EMPTY) entry_reg[0] <= push_data;
          else                      entry_reg[1] <= push_data;
          occ_reg <= occ_reg + OCC_ONE;
        end
        2'b01: begin
          entry_reg[0] <= entry_reg[1];
          occ_reg      <= occ_reg - OCC_ONE;
        end
        2'b11: begin
          if (occ_reg == OCC_FULL) begin
            entry_reg[0] <= entry_reg[1];
            entry_reg[1] <= push_data;
          end else begin
            entry_reg[0] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = entry_reg[0];
  assign occupancy = occ_reg;

  overflow_chk: assert property (@(posedge clk) disable iff (reset || flush)
                                 !(push && !pop_ok && occ_reg == OCC_FULL));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drives fifo_basic reads, absorbs its one-cycle read latency and presents
// the words as a valid/ready stream with flush and a handshake counter.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  logic                  inflight_reg;
  logic [CNT_WIDTH-1:0]  pop_count_reg;
  occ_t                  occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;
  logic                  push;

  assign m_valid = (occ != OCC_EMPTY) && !flush;
  assign pop     = m_valid && m_ready;
  // Reads landing during flush are thrown away rather than buffered.
  assign push    = inflight_reg && !flush;

  assign fifo_rd_en = !reset && !fifo_empty &&
                      (flush || has_credit(occ, inflight_reg, pop));

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg  <= 1'b0;
      pop_count_reg <= '0;
    end else begin
      inflight_reg <= fifo_rd_en;
      if (pop) pop_count_reg <= pop_count_reg + CNT_WIDTH'(1);
    end
  end

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .occupancy (occ)
  );

  assign m_data    = head;
  assign occupancy = occ;
  assign pop_count = pop_count_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural fifo_basic model feeding the DUT,
// scoreboard queue of expected stream words checked on every handshake.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;
  logic [CW-1:0] pop_count;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] fmem [0:255];
  int            fwr = 0;
  int            frd = 0;

  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_pop = '0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            rd_pulses = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held = '0;
  logic [DW-1:0] last_data = '0;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .flush      (flush),
    .occupancy  (occupancy),
    .pop_count  (pop_count)
  );

  always #5 clk = ~clk;

  // fifo_basic model: registered read data, valid the cycle after rd_en.
  assign fifo_empty = (fwr == frd);
  always @(posedge clk) begin
    if (wr_en) begin
      fmem[fwr % 256] <= wr_data;
      fwr <= fwr + 1;
    end
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[frd % 256];
      frd <= frd + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Words still inside the FIFO model are the only ones that can survive a
  // flush or reset of the reader.
  task automatic sb_rebuild();
    exp_q.delete();
    for (int i = frd; i < fwr; i++) exp_q.push_back(fmem[i % 256]);
  endtask

  task automatic drain(input int max_cycles);
    int k;
    for (k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && occupancy == 2'd0) break;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic latency_check(input string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fifo_rd_en) break;
    end
    chk({tag, "_rd_seen"}, fifo_rd_en, 1);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    chk({tag, "_latency"}, k + 1, 2);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_pop    = '0;
      stall_prev = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        rd_pulses++;
        chk("rd_en_vs_empty", fifo_empty, 0);
      end
      chk("occ_le_2", occupancy <= 2'd2, 1);
      if (flush) chk("valid_in_flush", m_valid, 0);
      if (stall_prev && !flush) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held);
      end
      if (m_valid && m_ready && !flush) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("m_data", m_data, exp_q.pop_front());
        chk("pop_count", pop_count, exp_pop);
        $display("word 0x%08h pop_count %0d", m_data, exp_pop);
        exp_pop   = exp_pop + 1'b1;
        last_data = m_data;
      end
      stall_prev = m_valid && !m_ready && !flush;
      held       = m_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_pop_count", pop_count, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Streaming with m_ready high, latency of the first word
    m_ready = 1'b1;
    fork
      begin
        write_word(32'h11111111);
        write_word(32'h22222222);
        write_word(32'h33333333);
        write_word(32'h44444444);
      end
      latency_check("t1");
    join
    drain(50);
    chk("t1_pop_count", pop_count, 4);

    // Backpressure: only two reads issued, head held
    m_ready   = 1'b0;
    rd_pulses = 0;
    write_word(32'h11111111);
    write_word(32'h22222222);
    write_word(32'h33333333);
    write_word(32'h44444444);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t2_rd_pulses", rd_pulses, 2);
    chk("t2_occ", occupancy, 2);
    chk("t2_head", m_data, 32'h11111111);
    m_ready = 1'b1;
    drain(50);
    chk("t2_last", last_data, 32'h44444444);

    // Toggling ready on an 8-word burst
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(DW'(i));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 m_ready = (i % 2) != 0;
    end
    m_ready = 1'b1;
    drain(50);
    chk("t3_last", last_data, 32'h7);

    // Flush with 6 words in the FIFO and 2 in the buffer
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(32'h100 + DW'(i));
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t4_occ_pre", occupancy, 2);
    @(posedge clk);
    #1 flush = 1'b1;
    m_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 flush = 1'b0;
    sb_rebuild();
    @(negedge clk);
    chk("t4_fifo_empty", fifo_empty, 1);
    chk("t4_occ_post", occupancy, 0);
    chk("t4_pop_count", pop_count, exp_pop);
    fork
      write_word(32'hA5A5A5A5);
      latency_check("t4");
    join
    drain(50);
    chk("t4_next_word", last_data, 32'hA5A5A5A5);

    // Reset mid-operation with a read in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(32'h500 + DW'(i));
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rd_en_in_reset", fifo_rd_en, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    sb_rebuild();
    @(negedge clk);
    chk("t5_occ", occupancy, 0);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_pop_count", pop_count, 0);
    write_word(32'hDEADBEEF);
    m_ready = 1'b1;
    drain(50);
    chk("t5_last", last_data, 32'hDEADBEEF);

    // Counter wrap with a 4-bit pop_count
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb_rebuild();
    for (int i = 0; i < 17; i++) write_word(32'hC00 + DW'(i));
    drain(100);
    chk("t6_pop_count_wrap", pop_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
